// File: rtl/xm_fetch_pkg.sv
// xm_fetch_pkg: shared state encoding, queue entry type and constants for the fetch sequencer
package xm_fetch_pkg;

    localparam int XM_WORD     = 16;
    localparam int INST_BYTES  = XM_WORD / 8;
    localparam int QUEUE_DEPTH = 2;

    typedef enum logic [2:0] {
        FS_IDLE    = 3'd0,
        FS_ISSUE   = 3'd1,
        FS_WAIT    = 3'd2,
        FS_CAPTURE = 3'd3,
        FS_FAULT   = 3'd4
    } fetch_seq_state_e;

    typedef struct packed {
        logic [XM_WORD-1:0] inst;
        logic [XM_WORD-1:0] pc;
    } fetch_entry_t;

    function automatic logic [XM_WORD-1:0] next_pc(input logic [XM_WORD-1:0] pc);
        return pc + XM_WORD'(INST_BYTES);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: 2-entry in-order FIFO of fetched instructions; slot 0 is always the head
module fetch_queue
    import xm_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output logic [1:0]   count,
    output logic         head_valid,
    output fetch_entry_t head
);

    fetch_entry_t ent0_q, ent0_d, ent1_q, ent1_d;
    logic [1:0]   count_q, count_d;
    logic [1:0]   slot;
    logic         do_pop, do_push;

    // Shift on pop, write the new entry into the first free slot after the pop
    always_comb begin
        do_pop  = pop && (count_q != 2'd0);
        do_push = push && ((count_q != 2'd2) || do_pop);
        slot    = count_q - {1'b0, do_pop};
        ent0_d  = do_pop ? ent1_q : ent0_q;
        ent1_d  = ent1_q;
        count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
        if (do_push && slot == 2'd0)
            ent0_d = push_data;
        if (do_push && slot != 2'd0)
            ent1_d = push_data;
        if (flush)
            count_d = 2'd0;
    end

    // Entry storage and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            ent0_q  <= '0;
            ent1_q  <= '0;
            count_q <= 2'd0;
        end else begin
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
            count_q <= count_d;
        end
    end

    assign count      = count_q;
    assign head_valid = (count_q != 2'd0);
    assign head       = ent0_q;

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC owner and request sequencer in front of Fetch_unit, feeding a 2-entry decode queue
// Optional build macro FETCH_SEQ_ALIGN_CHECK_EN: fault on an odd PC instead of forcing PC[0] to 0.
module fetch_sequencer
    import xm_fetch_pkg::*;
#(
    parameter int              WORD     = 16,
    parameter logic [WORD-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic            redirect,
    input  logic [WORD-1:0] redirect_addr,
    output logic            fetch_en,
    output logic [WORD-1:0] fetch_addr,
    input  logic            fetch_ready,
    input  logic            fetch_err,
    input  logic [WORD-1:0] fetch_inst,
    output logic            inst_valid,
    output logic [WORD-1:0] inst,
    output logic [WORD-1:0] inst_pc,
    input  logic            inst_ready,
    output logic            fault,
    output logic [WORD-1:0] fault_addr
);

    localparam int         DEPTH     = QUEUE_DEPTH;
    localparam logic [2:0] S_IDLE    = FS_IDLE;
    localparam logic [2:0] S_ISSUE   = FS_ISSUE;
    localparam logic [2:0] S_WAIT    = FS_WAIT;
    localparam logic [2:0] S_CAPTURE = FS_CAPTURE;
    localparam logic [2:0] S_FAULT   = FS_FAULT;
`ifdef FETCH_SEQ_ALIGN_CHECK_EN
    localparam logic [WORD-1:0] PC_MASK = '1;
`else
    localparam logic [WORD-1:0] PC_MASK = ~WORD'(1);
`endif

    logic [2:0]      state_q, state_d;
    logic [WORD-1:0] pc_q, pc_d;
    logic            fetch_en_q, fetch_en_d;
    logic [WORD-1:0] fetch_addr_q, fetch_addr_d;
    logic            fault_q, fault_d;
    logic [WORD-1:0] fault_addr_q, fault_addr_d;
    logic            drain_q, drain_d;

    logic         push_en, pop_en, can_issue;
    logic [1:0]   q_count, occ;
    logic         q_valid;
    fetch_entry_t q_head, push_entry;

    assign push_entry = '{inst: fetch_inst, pc: fetch_addr_q};

    // Next-state logic: redirect overrides everything, then the normal fetch sequence
    always_comb begin
        pop_en       = q_valid && inst_ready && !redirect;
        push_en      = (state_q == S_CAPTURE) && !redirect;
        occ          = q_count + {1'b0, push_en} - {1'b0, pop_en};
        can_issue    = run && !fault_q && fetch_ready && (occ < 2'(DEPTH));
        state_d      = state_q;
        pc_d         = pc_q;
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;
        drain_d      = drain_q;
        if (redirect) begin
            pc_d    = redirect_addr & PC_MASK;
            fault_d = 1'b0;
            state_d = (state_q == S_ISSUE || state_q == S_WAIT) ? S_WAIT : S_IDLE;
            drain_d = (state_q == S_ISSUE || state_q == S_WAIT);
        end else begin
            case (state_q)
                S_IDLE:    state_d = can_issue ? S_ISSUE : S_IDLE;
                S_ISSUE:   state_d = S_WAIT;
                S_WAIT: begin
                    if (fetch_ready && drain_q) begin
                        state_d = S_IDLE;
                        drain_d = 1'b0;
                    end else if (fetch_ready && fetch_err) begin
                        state_d      = S_FAULT;
                        fault_d      = 1'b1;
                        fault_addr_d = fetch_addr_q;
                    end else if (fetch_ready) begin
                        state_d = S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    pc_d    = next_pc(pc_q);
                    state_d = can_issue ? S_ISSUE : S_IDLE;
                end
                S_FAULT:   state_d = S_FAULT;
                default:   state_d = S_IDLE;
            endcase
        end
`ifdef FETCH_SEQ_ALIGN_CHECK_EN
        if (state_d == S_ISSUE && pc_d[0]) begin
            state_d      = S_FAULT;
            fault_d      = 1'b1;
            fault_addr_d = pc_d;
        end
`endif
        fetch_en_d   = (state_d == S_ISSUE);
        fetch_addr_d = fetch_en_d ? pc_d : fetch_addr_q;
    end

    // Sequencer state and registered request/fault outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC & PC_MASK;
            fetch_en_q   <= 1'b0;
            fetch_addr_q <= RESET_PC;
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
            drain_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fetch_en_q   <= fetch_en_d;
            fetch_addr_q <= fetch_addr_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
            drain_q      <= drain_d;
        end
    end

    fetch_queue u_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (push_en),
        .push_data  (push_entry),
        .pop        (pop_en),
        .flush      (redirect),
        .count      (q_count),
        .head_valid (q_valid),
        .head       (q_head)
    );

    assign fetch_en   = fetch_en_q;
    assign fetch_addr = fetch_addr_q;
    assign inst_valid = q_valid;
    assign inst       = q_head.inst;
    assign inst_pc    = q_head.pc;
    assign fault      = fault_q;
    assign fault_addr = fault_addr_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scenarios against a zero-wait ROM model of Fetch_unit
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset, run, redirect, inst_ready, rdy;
    logic [15:0] redirect_addr;
    logic        fetch_en, fetch_ready, fetch_err, inst_valid, fault;
    logic [15:0] fetch_addr, fetch_inst, inst, inst_pc, fault_addr;
    int          checks = 0;
    int          errors = 0;

    fetch_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .run           (run),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .fetch_en      (fetch_en),
        .fetch_addr    (fetch_addr),
        .fetch_ready   (fetch_ready),
        .fetch_err     (fetch_err),
        .fetch_inst    (fetch_inst),
        .inst_valid    (inst_valid),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .inst_ready    (inst_ready),
        .fault         (fault),
        .fault_addr    (fault_addr)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom(input logic [15:0] a);
        return (a == 16'h0000) ? 16'h1234 : (a == 16'h0002) ? 16'hABCD : (a ^ 16'h5A5A);
    endfunction

    assign fetch_inst  = rom(fetch_addr);
    assign fetch_err   = (fetch_addr == 16'h0040);
    assign fetch_ready = rdy;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1; run = 1'b0; redirect = 1'b0; redirect_addr = 16'h0; inst_ready = 1'b0; rdy = 1'b1;
        tick; tick;
        reset = 1'b0;
    endtask

    task automatic redir(input logic [15:0] a);
        redirect = 1'b1; redirect_addr = a;
        tick;
        redirect = 1'b0;
    endtask

    task automatic test_reset;
        int n;
        do_reset;
        run = 1'b1;
        repeat (4) tick;
        do_reset;
        checks++; if (fetch_en !== 1'b0) begin errors++; $display("FAIL rst_en got %h exp 0", fetch_en); end
        checks++; if (fetch_addr !== 16'h0000) begin errors++; $display("FAIL rst_addr got %h exp 0000", fetch_addr); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %h exp 0", inst_valid); end
        checks++; if (inst !== 16'h0000) begin errors++; $display("FAIL rst_inst got %h exp 0000", inst); end
        checks++; if (inst_pc !== 16'h0000) begin errors++; $display("FAIL rst_pc got %h exp 0000", inst_pc); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL rst_fault got %h exp 0", fault); end
        checks++; if (fault_addr !== 16'h0000) begin errors++; $display("FAIL rst_fault_addr got %h exp 0000", fault_addr); end
        n = 0;
        repeat (4) begin tick; n += int'(fetch_en) + int'(inst_valid); end
        checks++; if (n != 0) begin errors++; $display("FAIL rst_idle_activity got %0d exp 0", n); end
    endtask

    task automatic test_basic;
        logic        en_s [7];
        logic        v_s  [7];
        logic [15:0] a_s  [7];
        logic [15:0] i_s  [7];
        logic [15:0] p_s  [7];
        do_reset;
        run = 1'b1; inst_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick;
            en_s[i] = fetch_en; v_s[i] = inst_valid; a_s[i] = fetch_addr; i_s[i] = inst; p_s[i] = inst_pc;
        end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (en_s[i] !== (i % 3 == 0)) begin errors++; $display("FAIL basic_en[%0d] got %h exp %h", i, en_s[i], (i % 3 == 0)); end
        end
        checks++; if (a_s[0] !== 16'h0000) begin errors++; $display("FAIL basic_addr0 got %h exp 0000", a_s[0]); end
        checks++; if (a_s[3] !== 16'h0002) begin errors++; $display("FAIL basic_addr3 got %h exp 0002", a_s[3]); end
        checks++; if (v_s[2] !== 1'b0) begin errors++; $display("FAIL basic_valid2 got %h exp 0", v_s[2]); end
        checks++; if (v_s[3] !== 1'b1 || i_s[3] !== 16'h1234 || p_s[3] !== 16'h0000)
            begin errors++; $display("FAIL basic_first got v%h %h/%h exp v1 1234/0000", v_s[3], i_s[3], p_s[3]); end
        checks++; if (v_s[4] !== 1'b0) begin errors++; $display("FAIL basic_valid4 got %h exp 0", v_s[4]); end
        checks++; if (v_s[6] !== 1'b1 || i_s[6] !== 16'hABCD || p_s[6] !== 16'h0002)
            begin errors++; $display("FAIL basic_second got v%h %h/%h exp v1 ABCD/0002", v_s[6], i_s[6], p_s[6]); end
    endtask

    task automatic test_backpressure;
        int n;
        do_reset;
        run = 1'b1; inst_ready = 1'b0;
        n = 0;
        repeat (20) begin tick; n += int'(fetch_en); end
        checks++; if (n != 2) begin errors++; $display("FAIL bp_issues got %0d exp 2", n); end
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 16'h0000) begin errors++; $display("FAIL bp_head got v%h %h exp v1 0000", inst_valid, inst_pc); end
        inst_ready = 1'b1;
        tick;
        inst_ready = 1'b0;
        n = int'(fetch_en);
        checks++; if (inst_pc !== 16'h0002) begin errors++; $display("FAIL bp_pop_head got %h exp 0002", inst_pc); end
        repeat (12) begin tick; n += int'(fetch_en); end
        checks++; if (n != 1) begin errors++; $display("FAIL bp_reissue got %0d exp 1", n); end
        checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL bp_refill got %h exp 1", inst_valid); end
    endtask

    task automatic test_redirect;
        bit found;
        do_reset;
        run = 1'b1; inst_ready = 1'b0;
        repeat (4) tick;
        rdy = 1'b0;
        tick;
        redir(16'h0100);
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL redir_flush got %h exp 0", inst_valid); end
        tick;
        checks++; if (fetch_en !== 1'b0) begin errors++; $display("FAIL redir_drain_en got %h exp 0", fetch_en); end
        rdy = 1'b1;
        tick;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL redir_discard got %h exp 0", inst_valid); end
        inst_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin tick; found = fetch_en; end
        checks++; if (!found || fetch_addr !== 16'h0100) begin errors++; $display("FAIL redir_addr got en%h %h exp en1 0100", found, fetch_addr); end
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin tick; found = inst_valid; end
        checks++; if (!found || inst_pc !== 16'h0100 || inst !== 16'h5B5A)
            begin errors++; $display("FAIL redir_deliver got v%h %h/%h exp v1 5B5A/0100", found, inst, inst_pc); end
    endtask

    task automatic test_wrap;
        bit found;
        do_reset;
        redir(16'hFFFE);
        run = 1'b1; inst_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin tick; found = fetch_en; end
        checks++; if (!found || fetch_addr !== 16'hFFFE) begin errors++; $display("FAIL wrap_first got en%h %h exp en1 FFFE", found, fetch_addr); end
        tick;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin tick; found = fetch_en; end
        checks++; if (!found || fetch_addr !== 16'h0000) begin errors++; $display("FAIL wrap_next got en%h %h exp en1 0000", found, fetch_addr); end
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 16'hFFFE) begin errors++; $display("FAIL wrap_pc got v%h %h exp v1 FFFE", inst_valid, inst_pc); end
    endtask

    task automatic test_fault;
        bit found;
        int n;
        do_reset;
        redir(16'h0040);
        run = 1'b1; inst_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin tick; found = fetch_en; end
        checks++; if (!found || fetch_addr !== 16'h0040) begin errors++; $display("FAIL fault_issue got en%h %h exp en1 0040", found, fetch_addr); end
        tick; tick;
        checks++; if (fault !== 1'b1 || fault_addr !== 16'h0040) begin errors++; $display("FAIL fault_set got %h %h exp 1 0040", fault, fault_addr); end
        n = 0;
        repeat (10) begin tick; n += int'(fetch_en) + int'(inst_valid); end
        checks++; if (n != 0) begin errors++; $display("FAIL fault_hold got %0d exp 0", n); end
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL fault_sticky got %h exp 1", fault); end
        redir(16'h0080);
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL fault_clear got %h exp 0", fault); end
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin tick; found = fetch_en; end
        checks++; if (!found || fetch_addr !== 16'h0080) begin errors++; $display("FAIL fault_resume got en%h %h exp en1 0080", found, fetch_addr); end
    endtask

    task automatic test_align;
        bit found;
        int n;
        do_reset;
        redir(16'h0011);
        run = 1'b1; inst_ready = 1'b1;
`ifdef FETCH_SEQ_ALIGN_CHECK_EN
        tick; tick;
        checks++; if (fault !== 1'b1 || fault_addr !== 16'h0011) begin errors++; $display("FAIL align_fault got %h %h exp 1 0011", fault, fault_addr); end
        n = 0;
        repeat (8) begin tick; n += int'(fetch_en); end
        checks++; if (n != 0) begin errors++; $display("FAIL align_no_issue got %0d exp 0", n); end
`else
        n = 0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin tick; found = fetch_en; end
        checks++; if (!found || fetch_addr !== 16'h0010) begin errors++; $display("FAIL align_force got en%h %h exp en1 0010", found, fetch_addr); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL align_nofault got %h exp 0", fault); end
`endif
    endtask

    initial begin
        test_reset;
        test_basic;
        test_backpressure;
        test_redirect;
        test_wrap;
        test_fault;
        test_align;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Fetch-side front end of the X-Makina multi-cycle core: owns the program counter, issues word requests to `Fetch_unit` over its `en/addr/ready/inst` handshake, and buffers returned instructions with their PC in a 2-entry queue toward decode. It sits directly upstream of `Fetch_unit` (driving its `en`/`addr`) and consumes its `inst`, `ready` and `err` outputs. It also handles control-flow redirects and flushes.

## Interface
- `WORD`, 16: instruction/address width.
- `RESET_PC`, 16'h0000: PC loaded on reset.
- `DEPTH`, 2: instruction-queue entries (fixed at 2; not user-tunable).
- `clk` in 1: clock, rising edge active.
- `reset` in 1: reset, synchronous, active-high.
- `run` in 1: fetch permitted; when 0, no new request is issued and an in-flight request still completes.
- `redirect` in 1: single-cycle control-flow change.
- `redirect_addr` in WORD: new PC.
- `fetch_en` out 1: request to `Fetch_unit`.
- `fetch_addr` out WORD: request address.
- `fetch_ready` in 1: `Fetch_unit` ready.
- `fetch_err` in 1: `Fetch_unit` error.
- `fetch_inst` in WORD: `Fetch_unit` instruction register.
- `inst_valid` out 1: queue head valid.
- `inst` out WORD: head instruction.
- `inst_pc` out WORD: head PC.
- `inst_ready` in 1: decode accepts head.
- `fault` out 1: sticky fetch fault.
- `fault_addr` out WORD: PC that faulted.

## Operation
- FSM states: IDLE, ISSUE, WAIT, CAPTURE, FAULT.
- IDLE → ISSUE when `run`, `fault`=0, `fetch_ready`=1 and the queue has space for one more entry.
- ISSUE drives `fetch_en`=1 for exactly one cycle, with `fetch_addr`=PC. The next state is WAIT.
- WAIT: `fetch_en`=0. On `fetch_ready`=1:
  - If `fetch_err`=1, go to FAULT.
  - Otherwise go to CAPTURE.
- CAPTURE: push {`fetch_inst`, issued PC} into the queue.
  - PC ← PC + WORD/8, modulo 2^WORD, so 16'hFFFE wraps to 16'h0000.
  - Next state is ISSUE if issue conditions still hold, otherwise IDLE.
- FAULT: set `fault`=1 and `fault_addr`=issued PC. Hold until `redirect` or `reset`.
- Queue: in-order FIFO.
  - Pop when `inst_valid & inst_ready`.
  - A push and a pop in the same cycle are both honoured and the count is unchanged.
  - Space check uses count + in-flight ≤ 2, so the queue never overflows.
- `redirect` has top priority in any state:
  - Flush the queue; `inst_valid`=0 next cycle.
  - PC ← `redirect_addr`; clear `fault`.
  - If a request is in flight (ISSUE/WAIT), set `drain`. Stay in WAIT until `fetch_ready`, then discard the result (no push, no PC increment, `fetch_err` ignored) and go to IDLE.
  - Simultaneous `redirect` and pop: the flush wins.
  - Simultaneous `redirect` and CAPTURE: the push is suppressed.
- `run` falling mid-request: the request completes and is captured, then the FSM idles.

## Timing
- Reset values: state IDLE, PC=`RESET_PC`, `fetch_en`=0, `fetch_addr`=`RESET_PC`, queue empty, `inst_valid`=0, `inst`=0, `inst_pc`=0, `fault`=0, `fault_addr`=0, `drain`=0.
- Reset mid-request drops everything; any `Fetch_unit` response arriving later is ignored.
- Latency, with a zero-wait ROM (`fetch_ready` seen in the first WAIT cycle):
  - Cycle 0: ISSUE.
  - Cycle 1: WAIT.
  - Cycle 2: CAPTURE.
  - Cycle 3: `inst_valid`=1.
- Steady-state throughput is one instruction per 3 cycles.
- `fetch_inst` is sampled only in CAPTURE, i.e. the cycle after WAIT sees `fetch_ready`=1.
- `fetch_addr` is registered and stable from ISSUE until the next ISSUE.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `FETCH_SEQ_ALIGN_CHECK_EN` defined:
  - Before ISSUE, if PC[0]=1, go directly to FAULT with `fault_addr`=PC; no request is issued.
  - A misaligned `redirect_addr` faults on the next issue attempt.
- Undefined: PC[0] is forced to 0 on reset and on redirect, and no alignment fault exists.
- `fetch_err` faulting is present in both builds.

## Structure
- Package `xm_fetch_pkg` holds:
  - the `fetch_seq_state_e` enum;
  - `fetch_entry_t` struct {inst, pc};
  - `INST_BYTES = WORD/8`.
- Sub-module `fetch_queue`: 2-entry synchronous FIFO of `fetch_entry_t`, with push, pop, flush, count, head and registered outputs.

## Test plan
- Reset, `run`=1, ROM returns 16'h1234 at 0 and 16'hABCD at 2, with `inst_ready`=1:
  - `fetch_en` pulses at cycles 0 and 3 with addresses 0 and 2;
  - `inst`/`inst_pc` read 1234/0000, then ABCD/0002.
- `inst_ready`=0 throughout: exactly 2 entries are queued, then `fetch_en` stays 0. Raising `inst_ready` for 1 cycle causes exactly one new ISSUE.
- `redirect` to 16'h0100 during WAIT:
  - the in-flight response is discarded and the queue is flushed;
  - the next `fetch_addr`=0100 and the first delivered `inst_pc`=0100.
- PC=16'hFFFE fetch completes: next `fetch_addr`=16'h0000.
- `fetch_err`=1 with `fetch_ready` at address 0x0040: `fault`=1, `fault_addr`=0040, no further `fetch_en`. A subsequent `redirect` clears `fault`.
- Alignment, `redirect` to 16'h0011:
  - with `FETCH_SEQ_ALIGN_CHECK_EN`, `fault`=1, `fault_addr`=0011, no `fetch_en`;
  - without it, `fetch_addr`=0010.
